aes_inv_key_expand_128: RTL

- Reverse-order AES-128 round-key generator for the decryption datapath.
- On a key load, it runs the forward schedule internally for 10 cycles to reach the round-10 key.
- It then walks backwards one round key per `next` strobe: round 10, 9, … down to 0, the order the inverse cipher consumes them.
- It keeps a copy of the round-10 key so that each new ciphertext block restarts in one cycle without re-expansion.

---
 rtl/aes_inv_key_expand_128.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_key_expand_128.sv
// Reverse-order AES-128 round-key generator for the inverse cipher.
// A key load runs the forward schedule for 10 cycles to reach the round-10 key.
// Each `next` strobe then steps back one round key, from round 10 down to 0.
// The round-10 key is cached so a new block can restart in one cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   kld, key[127:0]     load cipher key (word 0 = key[127:96]) and expand
//   next                step back one round (READY only)
//   restart             reload cached round-10 key (READY only)
//   busy                forward expansion in progress
//   kvalid              wo_0..wo_3 hold a valid round key
//   round[3:0]          index of the presented round key, 0..10
//   wo_0..wo_3          round-key words, wo_0 is the MSW

// AES S-box computed as GF(2^8) inverse followed by the affine transform.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv_c;

  // a^254 = product of a^2, a^4, ..., a^128; maps 0 to 0 as the S-box requires.
  always_comb begin
    logic [7:0] sq;
    sq    = a;
    inv_c = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq    = gmul(sq, sq);
      inv_c = gmul(inv_c, sq);
    end
  end

  assign s = inv_c ^ {inv_c[6:0], inv_c[7]} ^ {inv_c[5:0], inv_c[7:6]}
           ^ {inv_c[4:0], inv_c[7:5]} ^ {inv_c[3:0], inv_c[7:4]} ^ 8'h63;

endmodule

module aes_inv_key_expand_128 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kld,
  input  logic [127:0] key,
  input  logic         next,
  input  logic         restart,
  output logic         busy,
  output logic         kvalid,
  output logic [3:0]   round,
  output logic [31:0]  wo_0,
  output logic [31:0]  wo_1,
  output logic [31:0]  wo_2,
  output logic [31:0]  wo_3
);

  localparam int unsigned ROUND_W = 4;
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(10);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [31:0]        w0_q, w1_q, w2_q, w3_q;
  logic [31:0]        w0_d, w1_d, w2_d, w3_d;
  logic [127:0]       cache_q, cache_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               busy_q, busy_d;
  logic               kvalid_q, kvalid_d;

  logic [31:0]        sbox_in_c;
  logic [31:0]        sub_rot_c;
  logic [ROUND_W-1:0] rcon_idx_c;
  logic [31:0]        t_c;
  logic [31:0]        f0_c, f1_c, f2_c, f3_c;
  logic [31:0]        p0_c, p1_c, p2_c, p3_c;

  function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Forward step needs w3; inverse step recovers previous w3 as w3^w2.
  assign sbox_in_c = (state_q == ST_EXPAND) ? w3_q : (w3_q ^ w2_q);

  // Shared S-boxes with RotWord folded into the byte wiring.
  aes_sbox u_sbox_0 (.a(sbox_in_c[23:16]), .s(sub_rot_c[31:24]));
  aes_sbox u_sbox_1 (.a(sbox_in_c[15:8]),  .s(sub_rot_c[23:16]));
  aes_sbox u_sbox_2 (.a(sbox_in_c[7:0]),   .s(sub_rot_c[15:8]));
  aes_sbox u_sbox_3 (.a(sbox_in_c[31:24]), .s(sub_rot_c[7:0]));

  // Forward step uses Rcon of the round being produced, inverse of the round being undone.
  assign rcon_idx_c = (state_q == ST_EXPAND) ? (round_q + ROUND_W'(1)) : round_q;
  assign t_c        = sub_rot_c ^ {rcon(rcon_idx_c), 24'h000000};

  assign f0_c = w0_q ^ t_c;
  assign f1_c = w1_q ^ f0_c;
  assign f2_c = w2_q ^ f1_c;
  assign f3_c = w3_q ^ f2_c;

  assign p3_c = w3_q ^ w2_q;
  assign p2_c = w2_q ^ w1_q;
  assign p1_c = w1_q ^ w0_q;
  assign p0_c = w0_q ^ t_c;

  // Next-state and next-output logic; priority kld > restart > next.
  always_comb begin
    state_d  = state_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    w2_d     = w2_q;
    w3_d     = w3_q;
    cache_d  = cache_q;
    round_d  = round_q;
    busy_d   = busy_q;
    kvalid_d = kvalid_q;

    if (kld) begin
      {w0_d, w1_d, w2_d, w3_d} = key;
      round_d  = '0;
      busy_d   = 1'b1;
      kvalid_d = 1'b0;
      state_d  = ST_EXPAND;
    end else begin
      case (state_q)
        ST_EXPAND: begin
          if (round_q < LAST_ROUND) begin
            {w0_d, w1_d, w2_d, w3_d} = {f0_c, f1_c, f2_c, f3_c};
            round_d = round_q + ROUND_W'(1);
            if (round_q == LAST_ROUND - ROUND_W'(1)) begin
              cache_d  = {f0_c, f1_c, f2_c, f3_c};
              busy_d   = 1'b0;
              kvalid_d = 1'b1;
              state_d  = ST_READY;
            end
          end
        end
        ST_READY: begin
          if (restart) begin
            {w0_d, w1_d, w2_d, w3_d} = cache_q;
            round_d = LAST_ROUND;
          end else if (next && (round_q != '0) && (round_q <= LAST_ROUND)) begin
            {w0_d, w1_d, w2_d, w3_d} = {p0_c, p1_c, p2_c, p3_c};
            round_d = round_q - ROUND_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      w0_q     <= '0;
      w1_q     <= '0;
      w2_q     <= '0;
      w3_q     <= '0;
      cache_q  <= '0;
      round_q  <= '0;
      busy_q   <= 1'b0;
      kvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      w2_q     <= w2_d;
      w3_q     <= w3_d;
      cache_q  <= cache_d;
      round_q  <= round_d;
      busy_q   <= busy_d;
      kvalid_q <= kvalid_d;
    end
  end

  assign busy   = busy_q;
  assign kvalid = kvalid_q;
  assign round  = round_q;
  assign wo_0   = w0_q;
  assign wo_1   = w1_q;
  assign wo_2   = w2_q;
  assign wo_3   = w3_q;

endmodule
